// File: rtl/asp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : asp_pkg
// Description : Shared opcode constants, arbitration pointer type and parity
//               helpers for the ASP issue scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package asp_pkg;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_LOAD    = 2'b01;
    localparam logic [1:0] OP_COMPARE = 2'b10;
    localparam logic [1:0] OP_NET     = 2'b11;

    // Widest word the parity helper accepts; narrower words are zero-extended,
    // which leaves their XOR unchanged.
    localparam int PARITY_MAX_W = 64;

    // Round-robin pointer: names the port that wins when both are pending.
    typedef enum logic {
        PRIO_HOST = 1'b0,
        PRIO_NET  = 1'b1
    } prio_t;

    // Parity bit that makes {parity, data} XOR to zero (even parity).
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

    // Only LOAD and COMPARE may be issued by the host.
    function automatic logic is_legal_host_op(input logic [1:0] op);
        return (op == OP_LOAD) || (op == OP_COMPARE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/asp_issue_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : asp_issue_sched_if
// Description : Host/network request handshakes and pipeline-side outputs of
//               the ASP issue scheduler. "master" is the requester/pipeline
//               side, "slave" is the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface asp_issue_sched_if #(
    parameter int DATA_SIZE = 32,
    parameter int TAG_SIZE  = 8
);
    logic                          host_valid;
    logic                          host_ready;
    logic [1:0]                    host_opcode;
    logic [DATA_SIZE-1:0]          host_data;
    logic                          host_err;
    logic                          net_valid;
    logic                          net_ready;
    logic [DATA_SIZE+TAG_SIZE-1:0] net_ndt;
    logic                          pipe_hold;
    logic [1:0]                    opcode_out;
    logic [DATA_SIZE:0]            dpp_out;
    logic [DATA_SIZE+TAG_SIZE-1:0] ndt_out;
    logic [15:0]                   host_issued;
    logic [15:0]                   net_issued;

    modport master (
        output host_valid, host_opcode, host_data, net_valid, net_ndt, pipe_hold,
        input  host_ready, host_err, net_ready, opcode_out, dpp_out, ndt_out,
               host_issued, net_issued
    );

    modport slave (
        input  host_valid, host_opcode, host_data, net_valid, net_ndt, pipe_hold,
        output host_ready, host_err, net_ready, opcode_out, dpp_out, ndt_out,
               host_issued, net_issued
    );
endinterface
`default_nettype wire

// File: rtl/asp_req_buffer.sv
`default_nettype none
// ============================================================================
// Module      : asp_req_buffer
// Description : One-entry valid/ready holding register. Ready whenever empty
//               or when the held entry is granted this cycle, so a granted
//               buffer can be refilled in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module asp_req_buffer #(
    parameter int WIDTH = 34
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             in_valid,
    output logic                  in_ready,
    input  wire logic [WIDTH-1:0] in_data,
    input  wire logic             grant,
    output logic                  buf_valid,
    output logic [WIDTH-1:0]      buf_data
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_accept;

    assign in_ready  = !r_valid || grant;
    assign w_accept  = in_valid && in_ready;
    assign buf_valid = r_valid;
    assign buf_data  = r_data;

    // Capture on accept; drain on grant when nothing replaces the entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (grant) begin
            r_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/asp_issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : asp_issue_sched
// Description : Shares the ASP first pipeline stage between the host command
//               port and the network port. Buffers one request per port,
//               arbitrates round-robin and loads an opcode/data-parity/ndt
//               word (or a NOP bubble) into the output register every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module asp_issue_sched
    import asp_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int TAG_SIZE  = 8
) (
    input  wire logic    clk,
    input  wire logic    reset,
    asp_issue_sched_if.slave bus
);
    localparam int HOST_W = 2 + DATA_SIZE;
    localparam int NDT_W  = DATA_SIZE + TAG_SIZE;

    logic                 w_host_bv;
    logic [HOST_W-1:0]    w_host_bd;
    logic                 w_net_bv;
    logic [NDT_W-1:0]     w_net_bd;
    logic                 w_host_grant;
    logic                 w_net_grant;
    logic [1:0]           w_host_op;
    logic [DATA_SIZE-1:0] w_host_data;
    logic [DATA_SIZE-1:0] w_net_data;

    prio_t                r_prio;
    prio_t                w_prio_nxt;

    logic [1:0]           r_opcode;
    logic [DATA_SIZE:0]   r_dpp;
    logic [NDT_W-1:0]     r_ndt;
    logic                 r_host_err;
    logic [15:0]          r_host_cnt;
    logic [15:0]          r_net_cnt;

    logic [1:0]           w_opcode_nxt;
    logic [DATA_SIZE:0]   w_dpp_nxt;
    logic [NDT_W-1:0]     w_ndt_nxt;
    logic                 w_err_nxt;
    logic                 w_host_inc;
    logic                 w_net_inc;

    asp_req_buffer #(.WIDTH(HOST_W)) u_host_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (bus.host_valid),
        .in_ready  (bus.host_ready),
        .in_data   ({bus.host_opcode, bus.host_data}),
        .grant     (w_host_grant),
        .buf_valid (w_host_bv),
        .buf_data  (w_host_bd)
    );

    asp_req_buffer #(.WIDTH(NDT_W)) u_net_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (bus.net_valid),
        .in_ready  (bus.net_ready),
        .in_data   (bus.net_ndt),
        .grant     (w_net_grant),
        .buf_valid (w_net_bv),
        .buf_data  (w_net_bd)
    );

    assign w_host_op   = w_host_bd[HOST_W-1:DATA_SIZE];
    assign w_host_data = w_host_bd[DATA_SIZE-1:0];
    assign w_net_data  = w_net_bd[NDT_W-1:TAG_SIZE];

    // A lone pending buffer always wins; a tie goes to the pointer's port.
    assign w_host_grant = !bus.pipe_hold && w_host_bv && (!w_net_bv || (r_prio == PRIO_HOST));
    assign w_net_grant  = !bus.pipe_hold && w_net_bv  && (!w_host_bv || (r_prio == PRIO_NET));

    // Pointer moves to the loser after a grant, holds otherwise.
    always_comb begin
        w_prio_nxt = r_prio;
        if (w_host_grant) begin
            w_prio_nxt = PRIO_NET;
        end else if (w_net_grant) begin
            w_prio_nxt = PRIO_HOST;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio <= PRIO_HOST;
        end else begin
            r_prio <= w_prio_nxt;
        end
    end

    // Build the next pipeline word; illegal host opcodes become a NOP bubble.
    always_comb begin
        w_opcode_nxt = OP_NOP;
        w_dpp_nxt    = '0;
        w_ndt_nxt    = '0;
        w_err_nxt    = 1'b0;
        w_host_inc   = 1'b0;
        w_net_inc    = 1'b0;
        if (w_host_grant) begin
            if (is_legal_host_op(w_host_op)) begin
                w_opcode_nxt = w_host_op;
                w_dpp_nxt    = {even_parity(PARITY_MAX_W'(w_host_data)), w_host_data};
                w_host_inc   = 1'b1;
            end else begin
                w_err_nxt    = 1'b1;
            end
        end else if (w_net_grant) begin
            w_opcode_nxt = OP_NET;
            w_dpp_nxt    = {even_parity(PARITY_MAX_W'(w_net_data)), w_net_data};
            w_ndt_nxt    = w_net_bd;
            w_net_inc    = 1'b1;
        end
    end

    // Output register and wrapping issue counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcode   <= OP_NOP;
            r_dpp      <= '0;
            r_ndt      <= '0;
            r_host_err <= 1'b0;
            r_host_cnt <= '0;
            r_net_cnt  <= '0;
        end else begin
            r_opcode   <= w_opcode_nxt;
            r_dpp      <= w_dpp_nxt;
            r_ndt      <= w_ndt_nxt;
            r_host_err <= w_err_nxt;
            if (w_host_inc) begin
                r_host_cnt <= r_host_cnt + 16'd1;
            end
            if (w_net_inc) begin
                r_net_cnt <= r_net_cnt + 16'd1;
            end
        end
    end

    assign bus.opcode_out  = r_opcode;
    assign bus.dpp_out     = r_dpp;
    assign bus.ndt_out     = r_ndt;
    assign bus.host_err    = r_host_err;
    assign bus.host_issued = r_host_cnt;
    assign bus.net_issued  = r_net_cnt;
endmodule
`default_nettype wire

// File: tb/tb_asp_issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_asp_issue_sched
// Description : Self-checking bench for asp_issue_sched. A queue-based
//               reference model tracks pending requests per port and the
//               round-robin preference, and predicts readies and outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asp_issue_sched;
    localparam int DS = 32;
    localparam int TS = 8;
    localparam int NW = DS + TS;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    asp_issue_sched_if #(.DATA_SIZE(DS), .TAG_SIZE(TS)) bus ();

    asp_issue_sched #(.DATA_SIZE(DS), .TAG_SIZE(TS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DS+1:0] hq[$];
    logic [NW-1:0] nq[$];
    bit            prefer_net;
    int            m_hcnt;
    int            m_ncnt;
    logic [1:0]    e_op;
    logic [DS:0]   e_dpp;
    logic [NW-1:0] e_ndt;
    logic          e_err;

    // One clock cycle: drive, check readies mid-cycle, advance model, check outputs.
    task automatic step(input logic rst_i, input logic hv, input logic [1:0] hop,
                        input logic [DS-1:0] hd, input logic nv, input logic [NW-1:0] nndt,
                        input logic hold);
        bit hg, ng, hr, nr;
        logic [DS+1:0] he;
        logic [NW-1:0] ne;
        logic [DS-1:0] d;
        reset            = rst_i;
        bus.host_valid   = hv;
        bus.host_opcode  = hop;
        bus.host_data    = hd;
        bus.net_valid    = nv;
        bus.net_ndt      = nndt;
        bus.pipe_hold    = hold;
        @(negedge clk);
        hg = 0;
        ng = 0;
        if (!hold) begin
            if (hq.size() != 0 && (nq.size() == 0 || !prefer_net)) hg = 1;
            else if (nq.size() != 0) ng = 1;
        end
        hr = (hq.size() == 0) || hg;
        nr = (nq.size() == 0) || ng;
        if (!rst_i) begin
            n_checks += 2;
            if (bus.host_ready !== hr) begin
                n_fail++;
                $display("FAIL host_ready @%0t: got %b expected %b", $time, bus.host_ready, hr);
            end
            if (bus.net_ready !== nr) begin
                n_fail++;
                $display("FAIL net_ready @%0t: got %b expected %b", $time, bus.net_ready, nr);
            end
        end
        @(posedge clk);
        e_op = 2'b00; e_dpp = '0; e_ndt = '0; e_err = 1'b0;
        if (rst_i) begin
            hq.delete();
            nq.delete();
            prefer_net = 0;
            m_hcnt = 0;
            m_ncnt = 0;
        end else begin
            if (hg) begin
                he = hq.pop_front();
                d  = he[DS-1:0];
                if (he[DS+1:DS] == 2'b01 || he[DS+1:DS] == 2'b10) begin
                    e_op   = he[DS+1:DS];
                    e_dpp  = {^d, d};
                    m_hcnt = (m_hcnt + 1) % 65536;
                end else begin
                    e_err = 1'b1;
                end
                prefer_net = 1;
            end
            if (ng) begin
                ne     = nq.pop_front();
                d      = ne[NW-1:TS];
                e_op   = 2'b11;
                e_dpp  = {^d, d};
                e_ndt  = ne;
                m_ncnt = (m_ncnt + 1) % 65536;
                prefer_net = 0;
            end
            if (hv && hr) hq.push_back({hop, hd});
            if (nv && nr) nq.push_back(nndt);
        end
        #1;
        n_checks += 7;
        if (bus.opcode_out !== e_op) begin
            n_fail++; $display("FAIL opcode_out @%0t: got %h expected %h", $time, bus.opcode_out, e_op);
        end
        if (bus.dpp_out !== e_dpp) begin
            n_fail++; $display("FAIL dpp_out @%0t: got %h expected %h", $time, bus.dpp_out, e_dpp);
        end
        if (bus.ndt_out !== e_ndt) begin
            n_fail++; $display("FAIL ndt_out @%0t: got %h expected %h", $time, bus.ndt_out, e_ndt);
        end
        if (bus.host_err !== e_err) begin
            n_fail++; $display("FAIL host_err @%0t: got %b expected %b", $time, bus.host_err, e_err);
        end
        if (bus.host_issued !== 16'(m_hcnt)) begin
            n_fail++; $display("FAIL host_issued @%0t: got %0d expected %0d", $time, bus.host_issued, m_hcnt);
        end
        if (bus.net_issued !== 16'(m_ncnt)) begin
            n_fail++; $display("FAIL net_issued @%0t: got %0d expected %0d", $time, bus.net_issued, m_ncnt);
        end
        if ((^bus.dpp_out) !== 1'b0) begin
            n_fail++; $display("FAIL dpp_parity @%0t: got %b expected 0", $time, ^bus.dpp_out);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 2'b00, '0, 0, '0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 2'b00, '0, 0, '0, 0);
        step(1, 0, 2'b00, '0, 0, '0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.host_ready !== 1'b1 || bus.net_ready !== 1'b1 || bus.opcode_out !== 2'b00 ||
            bus.dpp_out !== '0 || bus.ndt_out !== '0 || bus.host_err !== 1'b0 ||
            bus.host_issued !== 16'd0 || bus.net_issued !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b%b op=%h dpp=%h ndt=%h err=%b cnt=%0d/%0d expected rdy=11 all others 0",
                     bus.host_ready, bus.net_ready, bus.opcode_out, bus.dpp_out, bus.ndt_out,
                     bus.host_err, bus.host_issued, bus.net_issued);
        end
    endtask

    task automatic test_host_only();
        do_reset();
        step(0, 1, 2'b01, 32'h0000_0001, 0, '0, 0);
        step(0, 0, 2'b00, '0, 0, '0, 0);
        n_checks++;
        if (bus.opcode_out !== 2'b01 || bus.dpp_out !== 33'h1_0000_0001 || bus.host_issued !== 16'd1) begin
            n_fail++;
            $display("FAIL host_only: got op=%h dpp=%h cnt=%0d expected op=01 dpp=100000001 cnt=1",
                     bus.opcode_out, bus.dpp_out, bus.host_issued);
        end
        idle(1);
        n_checks++;
        if (bus.opcode_out !== 2'b00) begin
            n_fail++; $display("FAIL host_only_bubble: got op=%h expected 00", bus.opcode_out);
        end
    endtask

    task automatic test_net_only();
        do_reset();
        step(0, 0, 2'b00, '0, 1, 40'h00_0000_03A5, 0);
        step(0, 0, 2'b00, '0, 0, '0, 0);
        n_checks++;
        if (bus.opcode_out !== 2'b11 || bus.dpp_out !== 33'h0_0000_0003 ||
            bus.ndt_out !== 40'h00_0000_03A5 || bus.net_issued !== 16'd1) begin
            n_fail++;
            $display("FAIL net_only: got op=%h dpp=%h ndt=%h cnt=%0d expected op=11 dpp=000000003 ndt=00000003a5 cnt=1",
                     bus.opcode_out, bus.dpp_out, bus.ndt_out, bus.net_issued);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] prev;
        do_reset();
        prev = 2'b00;
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 2'b01, $urandom, 1, {$urandom, 8'($urandom)}, 0);
            if (i >= 2) begin
                n_checks++;
                if (bus.opcode_out === prev) begin
                    n_fail++; $display("FAIL alternation cycle %0d: got %h twice, expected a change", i, prev);
                end
            end
            prev = bus.opcode_out;
        end
        n_checks++;
        if (bus.host_issued !== 16'd4 || bus.net_issued !== 16'd4) begin
            n_fail++;
            $display("FAIL saturated_counts: got %0d/%0d expected 4/4", bus.host_issued, bus.net_issued);
        end
    endtask

    task automatic test_hold();
        do_reset();
        step(0, 1, 2'b10, 32'hDEAD_BEEF, 1, 40'h12_3456_7890, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 2'b01, 32'h1111_1111, 1, 40'h99_8877_6655, 1);
            n_checks++;
            if (bus.opcode_out !== 2'b00 || bus.host_issued !== 16'd0 || bus.net_issued !== 16'd0) begin
                n_fail++;
                $display("FAIL hold_nop: got op=%h cnt=%0d/%0d expected op=00 cnt=0/0",
                         bus.opcode_out, bus.host_issued, bus.net_issued);
            end
        end
        step(0, 0, 2'b00, '0, 0, '0, 0);
        n_checks++;
        if (bus.opcode_out !== 2'b10) begin
            n_fail++; $display("FAIL hold_release_host: got op=%h expected 10", bus.opcode_out);
        end
        step(0, 0, 2'b00, '0, 0, '0, 0);
        n_checks++;
        if (bus.opcode_out !== 2'b11 || bus.ndt_out !== 40'h12_3456_7890) begin
            n_fail++; $display("FAIL hold_release_net: got op=%h ndt=%h expected op=11 ndt=1234567890",
                               bus.opcode_out, bus.ndt_out);
        end
    endtask

    task automatic test_illegal_op();
        do_reset();
        step(0, 1, 2'b11, 32'hFFFF_FFFF, 0, '0, 0);
        step(0, 1, 2'b01, 32'h0000_0007, 0, '0, 0);
        n_checks++;
        if (bus.opcode_out !== 2'b00 || bus.dpp_out !== '0 || bus.host_err !== 1'b1 || bus.host_issued !== 16'd0) begin
            n_fail++;
            $display("FAIL illegal_op: got op=%h dpp=%h err=%b cnt=%0d expected op=00 dpp=0 err=1 cnt=0",
                     bus.opcode_out, bus.dpp_out, bus.host_err, bus.host_issued);
        end
        step(0, 0, 2'b00, '0, 0, '0, 0);
        n_checks++;
        if (bus.opcode_out !== 2'b01 || bus.dpp_out !== 33'h1_0000_0007 || bus.host_err !== 1'b0 ||
            bus.host_issued !== 16'd1) begin
            n_fail++;
            $display("FAIL after_illegal: got op=%h dpp=%h err=%b cnt=%0d expected op=01 dpp=100000007 err=0 cnt=1",
                     bus.opcode_out, bus.dpp_out, bus.host_err, bus.host_issued);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(0, 1, 2'b01, 32'hA5A5_A5A5, 1, 40'h01_0203_0405, 0);
        step(0, 1, 2'b10, 32'h5A5A_5A5A, 1, 40'h06_0708_090A, 1);
        step(1, 0, 2'b00, '0, 0, '0, 0);
        idle(3);
        n_checks++;
        if (bus.opcode_out !== 2'b00 || bus.host_issued !== 16'd0 || bus.net_issued !== 16'd0 ||
            bus.host_ready !== 1'b1 || bus.net_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: got op=%h cnt=%0d/%0d rdy=%b%b expected op=00 cnt=0/0 rdy=11",
                     bus.opcode_out, bus.host_issued, bus.net_issued, bus.host_ready, bus.net_ready);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(0, 1'($urandom_range(0, 1)), 2'($urandom), $urandom,
                 1'($urandom_range(0, 1)), {$urandom, 8'($urandom)},
                 ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.host_valid  = 1'b0;
        bus.host_opcode = 2'b00;
        bus.host_data   = '0;
        bus.net_valid   = 1'b0;
        bus.net_ndt     = '0;
        bus.pipe_hold   = 1'b0;
        prefer_net      = 0;
        m_hcnt          = 0;
        m_ncnt          = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_host_only();
        test_net_only();
        test_back_to_back();
        test_hold();
        test_illegal_op();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
